// File: rtl/sha256_compress.sv
`default_nettype none
// ============================================================================
// Module      : sha256_compress
// Description : Iterative SHA-256 compression engine. It processes one
//               512-bit block at one round per clock over 64 rounds, and
//               holds the chained hash H0..H7 between blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_compress #(
   parameter int DATA_WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic         init_i,
   input  logic [511:0] block_i,
   output logic         ready_o,
   output logic         done_o,
   output logic [255:0] hash_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ROUND  = 2'd1;
   localparam logic [1:0] S_UPDATE = 2'd2;

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x, input int n);
      return (x >> n) | (x << (DATA_WIDTH - n));
   endfunction

   logic [1:0]            state_q, state_d;
   logic [5:0]            t_q, t_d;
   logic                  done_q, done_d;
   logic [255:0]          hash_q, hash_d;
   logic [DATA_WIDTH-1:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
   logic [DATA_WIDTH-1:0] a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
   logic [DATA_WIDTH-1:0] w_q [16];
   logic [DATA_WIDTH-1:0] w_d [16];
   logic [DATA_WIDTH-1:0] w_t, t1, t2, sig0, sig1, ch, maj;
   logic [255:0]          start_hv;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: accept in IDLE, 64 rounds, then one update cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_i) state_d = S_ROUND;
         S_ROUND:  if (t_q == 6'd63) state_d = S_UPDATE;
         S_UPDATE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs: ready whenever idle (including the done cycle)
   always_comb begin
      ready_o = (state_q == S_IDLE);
      done_o  = done_q;
      hash_o  = hash_q;
   end

   // Round datapath and schedule; window rotates for t<16 so that from t=16 on it holds W[t-16..t-1]
   always_comb begin
      w_t  = (t_q < 6'd16) ? w_q[0]
           : (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
           + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
      sig1 = rotr(e_q, 6) ^ rotr(e_q, 11) ^ rotr(e_q, 25);
      sig0 = rotr(a_q, 2) ^ rotr(a_q, 13) ^ rotr(a_q, 22);
      ch   = (e_q & f_q) ^ (~e_q & g_q);
      maj  = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
      t1   = h_q + sig1 + ch + K[t_q] + w_t;
      t2   = sig0 + maj;
      start_hv = init_i ? IV : hash_q;

      t_d = t_q; done_d = 1'b0; hash_d = hash_q;
      a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
      e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
      for (int i = 0; i < 16; i++) w_d[i] = w_q[i];

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               for (int i = 0; i < 16; i++) w_d[i] = block_i[511 - 32*i -: 32];
               if (init_i) hash_d = IV;
               {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = start_hv;
               t_d = 6'd0;
            end
         end
         S_ROUND: begin
            for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
            w_d[15] = w_t;
            h_d = g_q; g_d = f_q; f_d = e_q; e_d = d_q + t1;
            d_d = c_q; c_d = b_q; b_d = a_q; a_d = t1 + t2;
            t_d = t_q + 6'd1;
         end
         S_UPDATE: begin
            hash_d = {hash_q[255:224] + a_q, hash_q[223:192] + b_q,
                      hash_q[191:160] + c_q, hash_q[159:128] + d_q,
                      hash_q[127:96]  + e_q, hash_q[95:64]   + f_q,
                      hash_q[63:32]   + g_q, hash_q[31:0]    + h_q};
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_q <= '0; done_q <= 1'b0; hash_q <= '0;
         a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
         e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else begin
         t_q <= t_d; done_q <= done_d; hash_q <= hash_d;
         a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
         e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
         for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
      end
   end

endmodule
`default_nettype wire
